// File: rtl/vr_tg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : vr_tg_pkg                                                    |
// | Description : Shared types and constants for the NIC traffic generator:    |
// |               traffic pattern and FSM state enums, LFSR taps, and flit     |
// |               field offset helpers.                                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package vr_tg_pkg;

    typedef enum logic [1:0] {
        PAT_UNIFORM   = 2'd0,
        PAT_TRANSPOSE = 2'd1,
        PAT_NEIGHBOUR = 2'd2,
        PAT_HOTSPOT   = 2'd3
    } tg_pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tg_state_e;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [15:0] c_lfsr_taps         = 16'hB400;
    localparam logic [15:0] c_lfsr_default_seed = 16'hACE1;

    // Top bit of the destination field: it sits directly below the VC field.
    function automatic int dest_msb(input int fw, input int vc_bits);
        return fw - vc_bits - 1;
    endfunction

    // Lowest bit of the source field: it sits directly above the sequence id.
    function automatic int src_lsb(input int id_bits);
        return id_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tg_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tg_lfsr16                                                    |
// | Description : 16-bit Galois LFSR with parallel load and step enable.       |
// |   clk        in   clock                                                    |
// |   rst        in   asynchronous active-high reset, loads SEED               |
// |   load       in   load load_value (wins over step)                         |
// |   step       in   advance one state                                        |
// |   load_value in   16-bit value for load                                    |
// |   lfsr       out  current state                                            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tg_lfsr16
    import vr_tg_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] load_value,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_value;
        end else if (step) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_lfsr_taps : 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/nic_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nic_traffic_gen                                              |
// | Description : Per-node torus traffic generator and ejection checker.       |
// |   enable/pattern/rate/num_flits  run control (pattern latched at start)    |
// |   nic_output_valid/data          injection port, one flit per valid cycle  |
// |   nic_input_valid/data           ejection port, counted and dest-checked   |
// |   flits_sent                     flits injected in the current run         |
// |   flits_received/misroute_count  saturating sink counters since reset      |
// |   error                          sticky misroute flag                      |
// |   done                           run has issued num_flits flits            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module nic_traffic_gen
    import vr_tg_pkg::*;
#(
    parameter int          ROW_COUNT       = 5,
    parameter int          COL_COUNT       = 5,
    parameter int          NUM_VC          = 4,
    parameter int          ROUTER_ID       = 0,
    parameter int          ID_BITS         = 12,
    parameter int          HOTSPOT         = 0,
    parameter logic [15:0] SEED            = 16'hACE1,
    parameter int          FLIT_DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 pattern,
    input  logic [7:0]                 rate,
    input  logic [15:0]                num_flits,
    output logic                       nic_output_valid,
    output logic [FLIT_DATA_WIDTH-1:0] nic_output_data,
    input  logic                       nic_input_valid,
    input  logic [FLIT_DATA_WIDTH-1:0] nic_input_data,
    output logic [15:0]                flits_sent,
    output logic [15:0]                flits_received,
    output logic [15:0]                misroute_count,
    output logic                       error,
    output logic                       done
);

    localparam int c_num_routers = ROW_COUNT * COL_COUNT;
    localparam int c_vc_bits     = $clog2(NUM_VC);
    localparam int c_rid_bits    = $clog2(c_num_routers);
    localparam int c_dest_msb    = dest_msb(FLIT_DATA_WIDTH, c_vc_bits);
    localparam int c_src_lsb     = src_lsb(ID_BITS);
    localparam int c_my_row      = ROUTER_ID / COL_COUNT;
    localparam int c_my_col      = ROUTER_ID % COL_COUNT;

    localparam logic [c_rid_bits-1:0] c_self           = c_rid_bits'(ROUTER_ID);
    localparam logic [c_rid_bits-1:0] c_self_next      = c_rid_bits'((ROUTER_ID + 1) % c_num_routers);
    localparam logic [c_rid_bits-1:0] c_transpose_dest = c_rid_bits'(c_my_col * COL_COUNT + c_my_row);
    localparam logic [c_rid_bits-1:0] c_neighbour_dest =
        c_rid_bits'(c_my_row * COL_COUNT + (c_my_col + 1) % COL_COUNT);
    localparam logic [c_rid_bits-1:0] c_hotspot_dest   = c_rid_bits'(HOTSPOT);
    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [15:0] c_seed = (SEED == 16'h0000) ? c_lfsr_default_seed : SEED;

    generate
        if (FLIT_DATA_WIDTH < c_vc_bits + 2 * c_rid_bits + ID_BITS) begin : g_chk_width
            $error("nic_traffic_gen: FLIT_DATA_WIDTH too small for flit fields");
        end
        if (ROW_COUNT != COL_COUNT) begin : g_chk_square
            $error("nic_traffic_gen: TRANSPOSE requires ROW_COUNT == COL_COUNT");
        end
    endgenerate

    tg_state_e                  state_q,   state_d;
    tg_pattern_e                pattern_q, pattern_d;
    logic [15:0]                sent_q,    sent_d;
    logic [ID_BITS-1:0]         seq_q,     seq_d;
    logic                       valid_q,   valid_d;
    logic [FLIT_DATA_WIDTH-1:0] flit_q,    flit_d;
    logic [15:0]                recv_q,    recv_d;
    logic [15:0]                mis_q,     mis_d;
    logic                       error_q,   error_d;

    logic [15:0]           w_lfsr;
    logic                  w_lfsr_step;
    logic                  w_inject;
    logic [c_rid_bits-1:0] w_uniform_raw;
    logic [c_rid_bits-1:0] w_uniform;
    logic [c_rid_bits-1:0] w_dest;
    logic [c_rid_bits-1:0] w_rx_dest;
    logic                  w_sink_unused;

    // Reset is the only seeding path; the load port is kept for reuse elsewhere.
    tg_lfsr16 #(
        .SEED (c_seed)
    ) u_lfsr (
        .clk        (clk),
        .rst        (reset),
        .load       (1'b0),
        .step       (w_lfsr_step),
        .load_value (c_seed),
        .lfsr       (w_lfsr)
    );

    assign w_inject = (w_lfsr[7:0] < rate) || (rate == 8'hFF);

    // Uniform picks from the upper LFSR byte; a self hit is bumped to the next node.
    assign w_uniform_raw = c_rid_bits'({8'h00, w_lfsr[15:8]} % 16'(c_num_routers));
    assign w_uniform     = (w_uniform_raw == c_self) ? c_self_next : w_uniform_raw;

    always_comb begin
        w_dest = w_uniform;
        case (pattern_q)
            PAT_UNIFORM:   w_dest = w_uniform;
            PAT_TRANSPOSE: w_dest = c_transpose_dest;
            PAT_NEIGHBOUR: w_dest = c_neighbour_dest;
            PAT_HOTSPOT:   w_dest = c_hotspot_dest;
            default:       w_dest = w_uniform;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        sent_d      = sent_q;
        seq_d       = seq_q;
        valid_d     = 1'b0;
        flit_d      = '0;
        w_lfsr_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    pattern_d = tg_pattern_e'(pattern);
                    sent_d    = 16'd0;
                    seq_d     = '0;
                    state_d   = (num_flits == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                w_lfsr_step = 1'b1;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (w_inject) begin
                    valid_d                           = 1'b1;
                    flit_d[c_dest_msb -: c_rid_bits]  = w_dest;
                    flit_d[c_src_lsb +: c_rid_bits]   = c_self;
                    flit_d[ID_BITS-1:0]               = seq_q;
                    sent_d                            = sent_q + 16'd1;
                    seq_d                             = seq_q + ID_BITS'(1);
                    // Leave on the issuing cycle so done rises with the last valid.
                    if (sent_q + 16'd1 == num_flits) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sink runs regardless of generator state.
    assign w_rx_dest     = nic_input_data[c_dest_msb -: c_rid_bits];
    assign w_sink_unused = ^{nic_input_data[FLIT_DATA_WIDTH-1:c_dest_msb+1],
                             nic_input_data[c_dest_msb-c_rid_bits:0]};

    always_comb begin
        recv_d  = recv_q;
        mis_d   = mis_q;
        error_d = error_q;
        if (nic_input_valid) begin
            if (recv_q != 16'hFFFF) begin
                recv_d = recv_q + 16'd1;
            end
            if (w_rx_dest != c_self) begin
                error_d = 1'b1;
                if (mis_q != 16'hFFFF) begin
                    mis_d = mis_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pattern_q <= PAT_UNIFORM;
            sent_q    <= 16'd0;
            seq_q     <= '0;
            valid_q   <= 1'b0;
            flit_q    <= '0;
            recv_q    <= 16'd0;
            mis_q     <= 16'd0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            sent_q    <= sent_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            flit_q    <= flit_d;
            recv_q    <= recv_d;
            mis_q     <= mis_d;
            error_q   <= error_d;
        end
    end

    assign nic_output_valid = valid_q;
    assign nic_output_data  = flit_q;
    assign flits_sent       = sent_q;
    assign flits_received   = recv_q;
    assign misroute_count   = mis_q;
    assign error            = error_q;
    assign done             = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nic_traffic_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nic_traffic_gen                                           |
// | Description : Self-checking bench for nic_traffic_gen. Three generators    |
// |               (ROUTER_ID 4, 7, 12) on a 5x5 torus share control inputs and |
// |               are compared against a cycle-level model of the generator.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_nic_traffic_gen;

    localparam int FW  = 32;
    localparam int N   = 3;
    localparam int HOT = 18;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    pattern;
    logic [7:0]    rate;
    logic [15:0]   num_flits;
    logic          nic_input_valid;
    logic [FW-1:0] nic_input_data;

    logic          en      [N];
    logic          o_valid [N];
    logic [FW-1:0] o_data  [N];
    logic [15:0]   o_sent  [N];
    logic [15:0]   o_recv  [N];
    logic [15:0]   o_mis   [N];
    logic          o_err   [N];
    logic          o_done  [N];

    logic [15:0]   m_lfsr  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            nic_traffic_gen #(
                .ROW_COUNT       (5),
                .COL_COUNT       (5),
                .NUM_VC          (4),
                .ROUTER_ID       (g == 0 ? 4 : (g == 1 ? 7 : 12)),
                .ID_BITS         (12),
                .HOTSPOT         (HOT),
                .SEED            (SEED),
                .FLIT_DATA_WIDTH (FW)
            ) u_dut (
                .clk              (clk),
                .reset            (reset),
                .enable           (en[g]),
                .pattern          (pattern),
                .rate             (rate),
                .num_flits        (num_flits),
                .nic_output_valid (o_valid[g]),
                .nic_output_data  (o_data[g]),
                .nic_input_valid  (nic_input_valid),
                .nic_input_data   (nic_input_data),
                .flits_sent       (o_sent[g]),
                .flits_received   (o_recv[g]),
                .misroute_count   (o_mis[g]),
                .error            (o_err[g]),
                .done             (o_done[g])
            );
        end
    endgenerate

    function automatic int id_of(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 7 : 12);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Destination from the pattern rules using node row/column arithmetic.
    function automatic int exp_dest(input int k, input logic [1:0] pat, input logic [15:0] v);
        int id, r, c, d;
        id = id_of(k);
        r  = id / 5;
        c  = id % 5;
        case (pat)
            2'd0: begin
                d = int'(v[15:8]) % 25;
                if (d == id) d = (id + 1) % 25;
            end
            2'd1:    d = c * 5 + r;
            2'd2:    d = r * 5 + (c + 1) % 5;
            default: d = HOT;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] exp_flit(input int k, input int d, input int seq);
        return 32'((d << 25) + (id_of(k) << 12) + seq);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run on generator k, checked every cycle against the model.
    task automatic run_gen(input int k, input logic [1:0] pat, input logic [7:0] rt,
                           input int nf, input int budget, input bit expect_done);
        int sent, seq, cyc, d;
        logic [15:0] v;
        bit inj;
        @(negedge clk);
        pattern   = pat;
        rate      = rt;
        num_flits = 16'(nf);
        en[k]     = 1'b1;
        @(negedge clk);
        chk("start_valid", 32'(o_valid[k]), 32'd0);
        chk("start_sent",  32'(o_sent[k]),  32'd0);
        chk("start_done",  32'(o_done[k]),  32'(nf == 0));
        sent = 0;
        seq  = 0;
        cyc  = 0;
        while (nf != 0 && sent < nf && cyc < budget) begin
            v         = m_lfsr[k];
            inj       = (v[7:0] < rt) || (rt == 8'hFF);
            m_lfsr[k] = lfsr_next(v);
            @(negedge clk);
            cyc++;
            if (inj) begin
                d = exp_dest(k, pat, v);
                chk("valid", 32'(o_valid[k]), 32'd1);
                chk("flit",  o_data[k], exp_flit(k, d, seq));
                chk("dest_range", 32'(o_data[k][29:25] < 5'd25), 32'd1);
                if (pat == 2'd0)
                    chk("uniform_not_self", 32'(o_data[k][29:25] != 5'(id_of(k))), 32'd1);
                sent++;
                seq = (seq + 1) % 4096;
            end else begin
                chk("idle_valid", 32'(o_valid[k]), 32'd0);
                chk("idle_data",  o_data[k], 32'd0);
            end
            chk("flits_sent", 32'(o_sent[k]), 32'(sent));
            chk("done",       32'(o_done[k]), 32'(sent == nf));
        end
        if (expect_done)
            chk("run_complete", 32'(sent), 32'(nf));
        if (sent == nf) begin
            @(negedge clk);
            chk("post_valid", 32'(o_valid[k]), 32'd0);
            chk("post_done",  32'(o_done[k]),  32'd1);
        end
        en[k] = 1'b0;
        // Leaving RUN on enable low still advances the LFSR that cycle.
        if (sent != nf) m_lfsr[k] = lfsr_next(m_lfsr[k]);
        @(negedge clk);
        chk("idle_done", 32'(o_done[k]), 32'd0);
        chk("hold_sent", 32'(o_sent[k]), 32'(sent));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] f;
        reset           = 1'b1;
        pattern         = 2'd0;
        rate            = 8'd0;
        num_flits       = 16'd0;
        nic_input_valid = 1'b0;
        nic_input_data  = '0;
        for (int k = 0; k < N; k++) begin
            en[k]     = 1'b0;
            m_lfsr[k] = SEED;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk("rst_valid", 32'(o_valid[k]), 32'd0);
            chk("rst_data",  o_data[k],       32'd0);
            chk("rst_sent",  32'(o_sent[k]),  32'd0);
            chk("rst_recv",  32'(o_recv[k]),  32'd0);
            chk("rst_mis",   32'(o_mis[k]),   32'd0);
            chk("rst_err",   32'(o_err[k]),   32'd0);
            chk("rst_done",  32'(o_done[k]),  32'd0);
        end
        reset = 1'b0;

        run_gen(0, 2'd2, 8'hFF, 3, 10, 1'b1);      // NEIGHBOUR from node 4
        run_gen(1, 2'd1, 8'hFF, 1, 10, 1'b1);      // TRANSPOSE from node 7
        run_gen(0, 2'd0, 8'h00, 5, 100, 1'b0);     // rate 0 never injects
        run_gen(1, 2'd3, 8'hFF, 0, 10, 1'b1);      // zero flits: straight to DONE
        run_gen(2, 2'd0, 8'hFF, 4100, 4200, 1'b1); // UNIFORM, seq wraps
        repeat (4)
            run_gen(2, 2'($urandom_range(0, 3)), 8'($urandom_range(16, 254)),
                    int'($urandom_range(1, 20)), 5000, 1'b1);

        // Sink on node 7: five correct flits, then one addressed to node 8.
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            f               = $urandom;
            f[29:25]        = (i < 5) ? 5'd7 : 5'd8;
            nic_input_valid = 1'b1;
            nic_input_data  = f;
            @(negedge clk);
            nic_input_valid = 1'b0;
            nic_input_data  = $urandom;
            chk("sink_recv", 32'(o_recv[1]), 32'(i + 1));
            chk("sink_mis",  32'(o_mis[1]),  32'(i == 5));
            chk("sink_err",  32'(o_err[1]),  32'(i == 5));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        chk("sink_recv_final", 32'(o_recv[1]), 32'd6);
        chk("sink_mis_final",  32'(o_mis[1]),  32'd1);
        chk("sink_err_sticky", 32'(o_err[1]),  32'd1);

        // Reset in the middle of a run on node 12.
        @(negedge clk);
        pattern   = 2'd0;
        rate      = 8'hFF;
        num_flits = 16'd10;
        en[2]     = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", 32'(o_valid[2]), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid[2]), 32'd0);
        chk("mid_rst_data",  o_data[2],       32'd0);
        chk("mid_rst_sent",  32'(o_sent[2]),  32'd0);
        chk("mid_rst_done",  32'(o_done[2]),  32'd0);
        chk("mid_rst_recv",  32'(o_recv[1]),  32'd0);
        chk("mid_rst_mis",   32'(o_mis[1]),   32'd0);
        chk("mid_rst_err",   32'(o_err[1]),   32'd0);
        en[2] = 1'b0;
        for (int k = 0; k < N; k++) m_lfsr[k] = SEED;
        @(negedge clk);
        reset = 1'b0;

        // Exact flit contents here depend on the LFSR restarting from SEED.
        run_gen(2, 2'd0, 8'd128, 8, 5000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
